alu_issue_buf: RTL and testbench

ALU_ISSUE_BUF -- requirements
Module: alu_issue_buf

---
 rtl/alu_issue_buf_if.sv | 70 +++++++
 rtl/alu_issue_buf.sv | 130 +++++++++++++
 tb/tb_alu_issue_buf.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_buf_if.sv
// Shared micro-op / result types and the handshake bundle for alu_issue_buf.
package alu_issue_buf_pkg;

  typedef enum logic [3:0] {
    m_add = 4'd0,
    m_sub = 4'd1,
    m_and = 4'd2,
    m_or  = 4'd3,
    m_xor = 4'd4,
    m_shl = 4'd5
  } opcode_t;

  // Register value as broadcast on the result bus: data plus arithmetic flags.
  typedef struct packed {
    logic [15:0] val;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        pf;
    logic        af;
    logic        of;
  } reg_val_t;

  typedef struct packed {
    opcode_t     opcode;
    logic [1:0]  scale;
    logic [15:0] disp;
    logic [4:0]  dst;
    reg_val_t    src0_val;
    reg_val_t    src1_val;
  } micro_op_t;

endpackage

// Producer, result-broadcast and ALU-side signals of the issue buffer.
interface alu_issue_buf_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  import alu_issue_buf_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  micro_op_t                in_mop;
  logic [TAG_W-1:0]         in_src0_tag;
  logic                     in_src0_rdy;
  logic [TAG_W-1:0]         in_src1_tag;
  logic                     in_src1_rdy;
  logic                     wb_valid;
  logic [TAG_W-1:0]         wb_tag;
  reg_val_t                 wb_val;
  logic                     out_valid;
  logic                     out_ready;
  micro_op_t                out_mop;
  logic                     flush;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, in_mop, in_src0_tag, in_src0_rdy, in_src1_tag, in_src1_rdy,
    output wb_valid, wb_tag, wb_val, out_ready, flush,
    input  in_ready, out_valid, out_mop, count
  );

  modport slave (
    input  in_valid, in_mop, in_src0_tag, in_src0_rdy, in_src1_tag, in_src1_rdy,
    input  wb_valid, wb_tag, wb_val, out_ready, flush,
    output in_ready, out_valid, out_mop, count
  );

endinterface

// File: rtl/alu_issue_buf.sv
// In-order ALU issue buffer: circular queue of micro-ops whose source operands
// are woken by result-tag broadcasts; only the head may issue.
module alu_issue_buf
  import alu_issue_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input logic          clk,
  input logic          reset_n,
  alu_issue_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  micro_op_t        mop_q  [DEPTH];
  micro_op_t        mop_d  [DEPTH];
  logic [TAG_W-1:0] tag0_q [DEPTH];
  logic [TAG_W-1:0] tag0_d [DEPTH];
  logic [TAG_W-1:0] tag1_q [DEPTH];
  logic [TAG_W-1:0] tag1_d [DEPTH];
  logic [DEPTH-1:0] rdy0_q, rdy0_d, rdy1_q, rdy1_d;
  logic [DEPTH-1:0] wake0, wake1;

  logic in_ready, out_valid, push, pop;
  logic push_wake0, push_wake1;

  // Handshakes are derived from registered state only, so a full buffer
  // refuses a push even when the head pops in the same cycle.
  assign in_ready   = (count_q != CW'(DEPTH));
  assign out_valid  = (count_q != '0) && rdy0_q[head_q] && rdy1_q[head_q];
  assign push       = bus.in_valid && in_ready;
  assign pop        = out_valid && bus.out_ready;

  // An incoming micro-op can be woken by a broadcast in its own arrival cycle.
  assign push_wake0 = bus.wb_valid && !bus.in_src0_rdy && (bus.in_src0_tag == bus.wb_tag);
  assign push_wake1 = bus.wb_valid && !bus.in_src1_rdy && (bus.in_src1_tag == bus.wb_tag);

  // Per-entry wakeup: only live entries, never the one leaving this cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    logic [PW-1:0] rel;
    logic          occ;
    assign rel        = PW'(gi) - head_q;
    assign occ        = ({1'b0, rel} < count_q) && !(pop && (head_q == PW'(gi)));
    assign wake0[gi]  = bus.wb_valid && occ && !rdy0_q[gi] && (tag0_q[gi] == bus.wb_tag);
    assign wake1[gi]  = bus.wb_valid && occ && !rdy1_q[gi] && (tag1_q[gi] == bus.wb_tag);
  end

  // Next-state: wakeups, then push at tail, pop at head; flush overrides all.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mop_d   = mop_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    rdy0_d  = rdy0_q;
    rdy1_d  = rdy1_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (wake0[i]) begin
        mop_d[i].src0_val = bus.wb_val;
        rdy0_d[i]         = 1'b1;
      end
      if (wake1[i]) begin
        mop_d[i].src1_val = bus.wb_val;
        rdy1_d[i]         = 1'b1;
      end
    end

    if (push) begin
      mop_d[tail_q] = bus.in_mop;
      if (push_wake0) mop_d[tail_q].src0_val = bus.wb_val;
      if (push_wake1) mop_d[tail_q].src1_val = bus.wb_val;
      tag0_d[tail_q] = bus.in_src0_tag;
      tag1_d[tail_q] = bus.in_src1_tag;
      rdy0_d[tail_q] = bus.in_src0_rdy || push_wake0;
      rdy1_d[tail_q] = bus.in_src1_rdy || push_wake1;
      tail_d         = tail_q + PW'(1);
    end

    if (pop) head_d = head_q + PW'(1);

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers; payload is cleared too so out_mop reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rdy0_q  <= '0;
      rdy1_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mop_q[i]  <= '0;
        tag0_q[i] <= '0;
        tag1_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      mop_q   <= mop_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_mop   = mop_q[head_q];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_alu_issue_buf.sv
// Bench for alu_issue_buf: directed scenarios then random traffic, all
// checked against a queue-based reference model.
module tb_alu_issue_buf;
  import alu_issue_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  alu_issue_buf_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  alu_issue_buf #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the buffer is just an ordered list of waiting ops.
  typedef struct {
    micro_op_t  mop;
    logic [4:0] t0;
    logic [4:0] t1;
    bit         r0;
    bit         r1;
  } ent_t;
  ent_t mq[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ov();
    return (mq.size() > 0) && mq[0].r0 && mq[0].r1;
  endfunction

  // Apply one clock edge's worth of behaviour to the model.
  function automatic void model_step();
    int   n;
    bit   pop, push;
    ent_t e;
    n    = mq.size();
    pop  = model_ov() && bus.out_ready;
    push = bus.in_valid && (n != DEPTH);
    if (bus.flush) begin
      mq.delete();
      return;
    end
    if (bus.wb_valid) begin
      for (int i = (pop ? 1 : 0); i < n; i++) begin
        e = mq[i];
        if (!e.r0 && e.t0 == bus.wb_tag) begin e.mop.src0_val = bus.wb_val; e.r0 = 1; end
        if (!e.r1 && e.t1 == bus.wb_tag) begin e.mop.src1_val = bus.wb_val; e.r1 = 1; end
        mq[i] = e;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      e.mop = bus.in_mop;
      e.t0  = bus.in_src0_tag;
      e.t1  = bus.in_src1_tag;
      e.r0  = bus.in_src0_rdy;
      e.r1  = bus.in_src1_rdy;
      if (bus.wb_valid && !e.r0 && e.t0 == bus.wb_tag) begin e.mop.src0_val = bus.wb_val; e.r0 = 1; end
      if (bus.wb_valid && !e.r1 && e.t1 == bus.wb_tag) begin e.mop.src1_val = bus.wb_val; e.r1 = 1; end
      mq.push_back(e);
    end
  endfunction

  task automatic check_model();
    chk("count", bus.count, mq.size());
    chk("in_ready", bus.in_ready, mq.size() != DEPTH);
    chk("out_valid", bus.out_valid, model_ov());
    chk("mop_no_x", $isunknown(bus.out_mop), 1'b0);
    if (model_ov()) chk("out_mop", bus.out_mop, mq[0].mop);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  function automatic reg_val_t rv(input logic [15:0] v);
    reg_val_t r;
    r     = '0;
    r.val = v;
    return r;
  endfunction

  function automatic micro_op_t mk(input opcode_t op, input logic [15:0] d,
                                   input logic [15:0] a, input logic [15:0] b);
    micro_op_t m;
    m          = '0;
    m.opcode   = op;
    m.scale    = 2'd1;
    m.disp     = d;
    m.dst      = 5'd9;
    m.src0_val = rv(a);
    m.src1_val = rv(b);
    return m;
  endfunction

  task automatic idle_in();
    bus.in_valid    = 0;
    bus.in_mop      = '0;
    bus.in_src0_tag = '0;
    bus.in_src0_rdy = 0;
    bus.in_src1_tag = '0;
    bus.in_src1_rdy = 0;
    bus.wb_valid    = 0;
    bus.wb_tag      = '0;
    bus.wb_val      = '0;
    bus.flush       = 0;
  endtask

  task automatic set_push(input micro_op_t m, input logic [4:0] t0, input bit r0,
                          input logic [4:0] t1, input bit r1);
    bus.in_valid    = 1;
    bus.in_mop      = m;
    bus.in_src0_tag = t0;
    bus.in_src0_rdy = r0;
    bus.in_src1_tag = t1;
    bus.in_src1_rdy = r1;
  endtask

  initial begin
    reg_val_t  wbv;
    micro_op_t m;

    reset_n       = 1;
    bus.out_ready = 0;
    idle_in();
    #2 reset_n = 0;
    #1;
    chk("rst_count", bus.count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_mop", bus.out_mop, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;

    // Single fully-ready add issues the next cycle.
    set_push(mk(m_add, 16'd1, 16'd3, 16'd4), 5'd0, 1, 5'd0, 1);
    bus.out_ready = 1;
    cycle();
    idle_in();
    chk("r22_valid", bus.out_valid, 1);
    chk("r22_src0", bus.out_mop.src0_val.val, 16'd3);
    chk("r22_src1", bus.out_mop.src1_val.val, 16'd4);
    cycle();
    chk("r22_count", bus.count, 0);

    // src1 waits on tag 7; wakeup appears one cycle after the broadcast.
    set_push(mk(m_sub, 16'd2, 16'd10, 16'd0), 5'd3, 1, 5'd7, 0);
    cycle();
    idle_in();
    chk("r23_wait", bus.out_valid, 0);
    cycle();
    wbv     = rv(16'h0055);
    wbv.cf  = 1;
    wbv.of  = 1;
    bus.wb_valid = 1;
    bus.wb_tag   = 5'd7;
    bus.wb_val   = wbv;
    #1 chk("r23_no_bypass", bus.out_valid, 0);
    cycle();
    idle_in();
    chk("r23_valid", bus.out_valid, 1);
    chk("r23_src1", bus.out_mop.src1_val, wbv);
    cycle();

    // Fill, push against full with simultaneous pop, then keep wrapping.
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_push(mk(m_and, 16'(16 + i), 16'(i), 16'(i + 1)), 5'd0, 1, 5'd0, 1);
      cycle();
    end
    chk("r24_full_ready", bus.in_ready, 0);
    chk("r24_full_count", bus.count, 4);
    set_push(mk(m_or, 16'd99, 16'd0, 16'd0), 5'd0, 1, 5'd0, 1);
    bus.out_ready = 1;
    cycle();
    chk("r24_rejected", bus.count, 3);
    chk("r24_head", bus.out_mop.disp, 16'd17);
    for (int i = 0; i < 2; i++) begin
      set_push(mk(m_xor, 16'(20 + i), 16'(i), 16'(i)), 5'd0, 1, 5'd0, 1);
      cycle();
    end
    idle_in();
    repeat (5) cycle();

    // Blocked head holds back a ready younger op until its tag arrives.
    set_push(mk(m_add, 16'd30, 16'd0, 16'd5), 5'd2, 0, 5'd0, 1);
    cycle();
    set_push(mk(m_sub, 16'd31, 16'd6, 16'd7), 5'd0, 1, 5'd0, 1);
    cycle();
    idle_in();
    repeat (2) begin
      cycle();
      chk("r25_blocked", bus.out_valid, 0);
    end
    bus.wb_valid = 1;
    bus.wb_tag   = 5'd2;
    bus.wb_val   = rv(16'h0abc);
    cycle();
    idle_in();
    chk("r25_first", bus.out_mop.disp, 16'd30);
    cycle();
    chk("r25_second", bus.out_mop.disp, 16'd31);
    cycle();

    // Flush with a concurrent push drops everything.
    bus.out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      set_push(mk(m_shl, 16'(40 + i), 16'd1, 16'd1), 5'd0, 1, 5'd0, 1);
      cycle();
    end
    set_push(mk(m_add, 16'd50, 16'd1, 16'd1), 5'd0, 1, 5'd0, 1);
    bus.flush = 1;
    cycle();
    idle_in();
    chk("r26_count", bus.count, 0);
    chk("r26_valid", bus.out_valid, 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 2; i++) begin
      set_push(mk(m_add, 16'(60 + i), 16'd2, 16'd2), 5'd0, 1, 5'd0, 1);
      cycle();
    end
    idle_in();
    reset_n = 0;
    #1;
    chk("r27_count", bus.count, 0);
    chk("r27_in_ready", bus.in_ready, 1);
    chk("r27_valid", bus.out_valid, 0);
    mq.delete();
    bus.out_ready = 1;
    @(negedge clk);
    reset_n = 1;
    repeat (2) begin
      cycle();
      chk("r27_no_issue", bus.out_valid, 0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      m          = '0;
      m.opcode   = opcode_t'(4'($urandom_range(0, 5)));
      m.scale    = 2'($urandom);
      m.disp     = 16'($urandom);
      m.dst      = 5'($urandom);
      m.src0_val = reg_val_t'(22'($urandom));
      m.src1_val = reg_val_t'(22'($urandom));
      bus.in_valid    = ($urandom_range(0, 9) < 6);
      bus.in_mop      = m;
      bus.in_src0_tag = 5'($urandom_range(0, 3));
      bus.in_src0_rdy = ($urandom_range(0, 1) == 1);
      bus.in_src1_tag = 5'($urandom_range(0, 3));
      bus.in_src1_rdy = ($urandom_range(0, 1) == 1);
      bus.wb_valid    = ($urandom_range(0, 9) < 4);
      bus.wb_tag      = 5'($urandom_range(0, 3));
      bus.wb_val      = reg_val_t'(22'($urandom));
      bus.out_ready   = ($urandom_range(0, 9) < 7);
      bus.flush       = ($urandom_range(0, 49) == 0);
      cycle();
    end
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
